// File: rtl/shift_add_multiplier_if.sv
// shift_add_multiplier_if: handshake and operand/result bundle for shift_add_multiplier
// Signals:
//   start_i  - request pulse, sampled by the multiplier only when idle or done
//   signed_i - 1 = two's-complement operands, 0 = unsigned (sampled with start_i)
//   a_i, b_i - multiplicand / multiplier (sampled with start_i)
//   busy_o   - high while iterating
//   done_o   - one-cycle completion strobe
//   hi_o     - registered upper product half
//   lo_o     - registered lower product half
// Modports: master drives requests and observes results, slave is the multiplier.
interface shift_add_multiplier_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic             signed_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output start_i, signed_i, a_i, b_i,
        input  busy_o, done_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, signed_i, a_i, b_i,
        output busy_o, done_o, hi_o, lo_o
    );
endinterface

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: multi-cycle shift-and-add multiplier, one operand bit per clock
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-high reset
//   mif - shift_add_multiplier_if.slave (start/signed/a/b in, busy/done/hi/lo out)
// Configuration:
//   MULT_SIGNED_EN - when defined, signed_i selects magnitude conversion and sign fixup;
//                    when undefined, signed_i is ignored and every product is unsigned.
module shift_add_multiplier #(
    parameter int WIDTH = 32
) (
    input logic                   clk,
    input logic                   rst,
    shift_add_multiplier_if.slave mif
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [CW-1:0]      count_q, count_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               neg_in;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod, result;

`ifdef MULT_SIGNED_EN
    // The most negative value negates to itself, which read unsigned is exactly 2^(WIDTH-1).
    assign a_mag  = (mif.signed_i && mif.a_i[WIDTH-1]) ? -mif.a_i : mif.a_i;
    assign b_mag  = (mif.signed_i && mif.b_i[WIDTH-1]) ? -mif.b_i : mif.b_i;
    assign neg_in = mif.signed_i & (mif.a_i[WIDTH-1] ^ mif.b_i[WIDTH-1]);
    assign result = neg_q ? -prod : prod;
`else
    logic unused_signed;
    assign unused_signed = mif.signed_i;
    assign a_mag         = mif.a_i;
    assign b_mag         = mif.b_i;
    assign neg_in        = 1'b0;
    assign result        = prod;
`endif

    // The carry out of the add is kept as the top bit so the shift never loses it.
    assign sum  = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    // Full product as it will stand once this iteration's shift has happened.
    assign prod = {sum, mplier_q[WIDTH-1:1]};

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        if (state_q == RUN) begin
            acc_d    = sum[WIDTH:1];
            mplier_d = {sum[0], mplier_q[WIDTH-1:1]};
            count_d  = count_q + CW'(1);
            if (count_q == CW'(WIDTH - 1)) begin
                state_d = DONE;
                hi_d    = result[2*WIDTH-1:WIDTH];
                lo_d    = result[WIDTH-1:0];
            end
        end else if (mif.start_i) begin
            state_d  = RUN;
            mcand_d  = a_mag;
            mplier_d = b_mag;
            neg_d    = neg_in;
            acc_d    = '0;
            count_d  = '0;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign mif.busy_o = (state_q == RUN);
    assign mif.done_o = (state_q == DONE);
    assign mif.hi_o   = hi_q;
    assign mif.lo_o   = lo_q;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: randomized self-checking bench with a cycle-level behavioural model
module tb_shift_add_multiplier;
`ifdef MULT_SIGNED_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;

    shift_add_multiplier_if #(.WIDTH(32)) mif ();

    shift_add_multiplier #(.WIDTH(32)) dut (
        .clk(clk),
        .rst(rst),
        .mif(mif)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic signed [63:0] x, y;
        if (s && SGN) begin
            x = $signed(a);
            y = $signed(b);
            return x * y;
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: a product becomes visible 32 cycles after its Start is accepted,
    // and a Start is accepted only when no product is outstanding.
    int          m_left = 0;
    logic        m_done = 1'b0;
    logic [63:0] m_pend = '0;
    logic [63:0] m_res  = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left = 0;
            m_done = 1'b0;
            m_res  = '0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_res  = m_pend;
                m_done = 1'b1;
            end
        end else begin
            m_done = 1'b0;
            if (mif.start_i) begin
                m_left = 32;
                m_pend = ref_prod(mif.a_i, mif.b_i, mif.signed_i);
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_busy", 64'(mif.busy_o), 64'(m_left > 0));
        chk("cyc_done", 64'(mif.done_o), 64'(m_done));
        chk("cyc_hi", 64'(mif.hi_o), 64'(m_res[63:32]));
        chk("cyc_lo", 64'(mif.lo_o), 64'(m_res[31:0]));
    end

    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
        mif.start_i  = 1'b1;
        mif.a_i      = a;
        mif.b_i      = b;
        mif.signed_i = s;
        @(posedge clk);
        #1;
        mif.start_i  = 1'b0;
        mif.a_i      = $urandom;
        mif.b_i      = $urandom;
        mif.signed_i = 1'($urandom);
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (lat < 40) begin
            @(negedge clk);
            if (mif.done_o) break;
            lat++;
        end
        if (lat >= 40) chk("done_timeout", 64'(lat), 64'd33);
    endtask

    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [63:0] exp);
        int lat;
        @(posedge clk);
        #1;
        launch(a, b, s);
        wait_done(lat);
        chk({name, "_lat"}, 64'(lat), 64'd33);
        chk({name, "_hilo"}, {mif.hi_o, mif.lo_o}, exp);
    endtask

    initial begin
        int lat;
        int ndone;
        logic [31:0] a, b;
        logic s;
        mif.start_i  = 1'b0;
        mif.signed_i = 1'b0;
        mif.a_i      = '0;
        mif.b_i      = '0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", 64'(mif.busy_o), 64'd0);
        chk("rst_done", 64'(mif.done_o), 64'd0);
        chk("rst_hilo", {mif.hi_o, mif.lo_o}, 64'd0);

        chk("pin_3x5", ref_prod(32'd3, 32'd5, 1'b0), 64'h0000_0000_0000_000F);
        chk("pin_ff_u", ref_prod(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0), 64'hFFFF_FFFE_0000_0001);

        run_op("mul_3x5", 32'd3, 32'd5, 1'b0, 64'h0000_0000_0000_000F);
        run_op("ff_unsigned", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
        run_op("ff_signed", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1,
               SGN ? 64'h0000_0000_0000_0001 : 64'hFFFF_FFFE_0000_0001);
        run_op("m7x3_signed", 32'hFFFF_FFF9, 32'd3, 1'b1,
               SGN ? 64'hFFFF_FFFF_FFFF_FFEB : 64'h0000_0002_FFFF_FFEB);
        run_op("min_sq_signed", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);

        // Start during RUN is ignored; Start during the Done cycle is taken at once.
        @(posedge clk);
        #1;
        launch(32'd3, 32'd5, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        launch(32'd7, 32'd7, 1'b0);
        wait_done(lat);
        chk("ignore_lat", 64'(lat), 64'd23);
        chk("ignore_hilo", {mif.hi_o, mif.lo_o}, 64'd15);
        #1;
        launch(32'd7, 32'd7, 1'b0);
        wait_done(lat);
        chk("b2b_lat", 64'(lat), 64'd33);
        chk("b2b_hilo", {mif.hi_o, mif.lo_o}, 64'd49);

        // Asynchronous reset in the middle of an iteration.
        @(posedge clk);
        #1;
        launch(32'd9, 32'd9, 1'b0);
        repeat (19) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_busy", 64'(mif.busy_o), 64'd0);
        chk("arst_done", 64'(mif.done_o), 64'd0);
        chk("arst_hilo", {mif.hi_o, mif.lo_o}, 64'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (mif.done_o) ndone++;
        end
        chk("arst_no_done", 64'(ndone), 64'd0);
        run_op("after_rst_2x2", 32'd2, 32'd2, 1'b0, 64'd4);

        // Hi/Lo hold their previous result through a new operation.
        run_op("hold_3x5", 32'd3, 32'd5, 1'b0, 64'd15);
        @(posedge clk);
        #1;
        launch(32'd0, 32'd0, 1'b0);
        repeat (15) @(negedge clk);
        chk("hold_busy", 64'(mif.busy_o), 64'd1);
        chk("hold_hilo", {mif.hi_o, mif.lo_o}, 64'd15);
        wait_done(lat);
        chk("hold_lat", 64'(lat), 64'd18);
        chk("hold_final", {mif.hi_o, mif.lo_o}, 64'd0);

        // Randomized operands and modes, with a bias toward boundary values.
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = $urandom;
            s = 1'($urandom);
            if (i % 5 == 1) a = (i % 2) ? 32'h8000_0000 : 32'h7FFF_FFFF;
            if (i % 7 == 3) b = (i % 2) ? 32'hFFFF_FFFF : 32'd0;
            if (i % 4 == 0) begin
                #1;
                launch(a, b, s);
                wait_done(lat);
                chk("rand_b2b_lat", 64'(lat), 64'd33);
                chk("rand_b2b_hilo", {mif.hi_o, mif.lo_o}, ref_prod(a, b, s));
            end else begin
                run_op("rand", a, b, s, ref_prod(a, b, s));
            end
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
